// File: rtl/filter_load_ctrl.sv
// Filter scratchpad loader: streams filt_len words into rows 0..N-1,
// then holds the filter resident until the compute stage releases it.
module filter_load_ctrl #(
  parameter int FILTER_WIDTH = 16,
  parameter int FILTER_ROW   = 12,
  parameter int ADDR_W       = $clog2(FILTER_ROW),
  parameter int LEN_W        = $clog2(FILTER_ROW + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        filt_len,
  input  logic [FILTER_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    spad_wen,
  output logic [ADDR_W-1:0]       spad_waddr,
  output logic [FILTER_WIDTH-1:0] spad_din,
  output logic                    filt_valid,
  output logic [LEN_W-1:0]        filt_size,
  input  logic                    filt_release,
  output logic                    busy,
  output logic                    len_err
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_WR,
    HOLD
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] count_nx;
  logic             len_ok;
  logic             xfer;

  assign len_ok   = (filt_len != '0) &&
                    (filt_len <= LEN_W'(FILTER_ROW));
  assign count_nx = count + 1'b1;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      in_ready   <= 1'b0;
      spad_wen   <= 1'b0;
      spad_waddr <= '0;
      spad_din   <= '0;
      filt_valid <= 1'b0;
      filt_size  <= '0;
      busy       <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      len_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              filt_size <= filt_len;
              count     <= '0;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
              state     <= LOAD;
            end else begin
              len_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          spad_wen <= xfer;
          if (xfer) begin
            spad_waddr <= count[ADDR_W-1:0];
            spad_din   <= in_data;
            count      <= count_nx;
            if (count_nx == filt_size) begin
              in_ready <= 1'b0;
              state    <= WAIT_WR;
            end
          end
        end
        // First cycle drives the final write, second lets it commit.
        WAIT_WR: begin
          if (spad_wen) begin
            spad_wen <= 1'b0;
          end else begin
            filt_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (filt_release) begin
            filt_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_load_ctrl.sv
// Directed bench for filter_load_ctrl with a behavioural
// scratchpad that records every write it sees.
module tb_filter_load_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  filt_len;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        spad_wen;
  logic [3:0]  spad_waddr;
  logic [15:0] spad_din;
  logic        filt_valid;
  logic [3:0]  filt_size;
  logic        filt_release;
  logic        busy;
  logic        len_err;

  int tests = 0;
  int fails = 0;

  logic [15:0] mem [12];
  int          wa [$];
  logic [15:0] wd [$];

  filter_load_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .filt_len     (filt_len),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .spad_wen     (spad_wen),
    .spad_waddr   (spad_waddr),
    .spad_din     (spad_din),
    .filt_valid   (filt_valid),
    .filt_size    (filt_size),
    .filt_release (filt_release),
    .busy         (busy),
    .len_err      (len_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (spad_wen) begin
      if (spad_waddr < 4'd12) mem[spad_waddr] <= spad_din;
      wa.push_back(int'(spad_waddr));
      wd.push_back(spad_din);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word(
    input logic [15:0] base, input int i);
    return 16'(32'(base) * (i + 1));
  endfunction

  task automatic feed(input int n, input logic [15:0] base,
                      input bit rnd);
    int  idx = 0;
    int  cyc = 0;
    bit  x;
    in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    in_data  = word(base, idx);
    while (idx < n && cyc < 200) begin
      x = in_valid && in_ready;
      tick;
      cyc++;
      if (x) idx++;
      in_data  = word(base, idx);
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    in_valid = 1'b0;
    tests++;
    if (idx != n) begin
      fails++;
      $display("FAIL feed_count got %0d want %0d", idx, n);
    end
  endtask

  task automatic wait_valid;
    for (int i = 0; i < 10 && !filt_valid; i++) tick;
    tests++;
    if (filt_valid !== 1'b1) begin
      fails++;
      $display("FAIL wait_valid timeout filt_valid=%b", filt_valid);
    end
  endtask

  task automatic release_filt;
    filt_release = 1'b1;
    tick;
    filt_release = 1'b0;
    tests++;
    if ({filt_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL release valid/busy got %b%b want 00",
               filt_valid, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; filt_len = '0;
    in_data = '0; in_valid = 1'b0; filt_release = 1'b0;
    repeat (2) tick;
    tests++;
    if ({in_ready, spad_wen, spad_waddr, spad_din, filt_valid,
         filt_size, busy, len_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got %b wants all zero",
               {in_ready, spad_wen, spad_waddr, spad_din,
                filt_valid, filt_size, busy, len_err});
    end
    rst = 1'b1;
    tick;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic;
    wa.delete(); wd.delete();
    start = 1'b1; filt_len = 4'd3;
    tick;
    start = 1'b0;
    tests++;
    if ({busy, in_ready} !== 2'b11) begin
      fails++;
      $display("FAIL basic_load busy/ready got %b%b want 11",
               busy, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = word(16'h1111, i);
      tick;
      tests++;
      if ({spad_wen, spad_waddr, spad_din} !==
          {1'b1, 4'(i), word(16'h1111, i)}) begin
        fails++;
        $display("FAIL basic_wr%0d got %b/%0d/%h want 1/%0d/%h",
                 i, spad_wen, spad_waddr, spad_din, i,
                 word(16'h1111, i));
      end
    end
    in_valid = 1'b0;
    tests++;
    if ({filt_valid, in_ready} !== 2'b00) begin
      fails++;
      $display("FAIL basic_e0 valid/ready got %b%b want 00",
               filt_valid, in_ready);
    end
    tick;
    tests++;
    if ({spad_wen, filt_valid} !== 2'b00) begin
      fails++;
      $display("FAIL basic_e1 wen/valid got %b%b want 00",
               spad_wen, filt_valid);
    end
    tick;
    tests++;
    if ({filt_valid, busy, in_ready, filt_size} !==
        {3'b110, 4'd3}) begin
      fails++;
      $display("FAIL basic_e2 v/b/r/size got %b%b%b/%0d want 110/3",
               filt_valid, busy, in_ready, filt_size);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (mem[i] !== word(16'h1111, i)) begin
        fails++;
        $display("FAIL basic_mem%0d got %h want %h",
                 i, mem[i], word(16'h1111, i));
      end
    end
    tests++;
    if (wa.size() != 3) begin
      fails++;
      $display("FAIL basic_nwr got %0d want 3", wa.size());
    end
  endtask

  task automatic test_hold_start;
    wa.delete(); wd.delete();
    start = 1'b1; filt_len = 4'd5;
    tick;
    start = 1'b0;
    tick;
    tests++;
    if ({filt_valid, len_err, filt_size} !== {2'b10, 4'd3}) begin
      fails++;
      $display("FAIL hold_start v/err/size got %b%b/%0d want 10/3",
               filt_valid, len_err, filt_size);
    end
    release_filt;
    tests++;
    if (filt_size !== 4'd3) begin
      fails++;
      $display("FAIL hold_keep_size got %0d want 3", filt_size);
    end
    tick;
    start = 1'b1; filt_len = 4'd5;
    tick;
    start = 1'b0;
    tests++;
    if (filt_size !== 4'd5) begin
      fails++;
      $display("FAIL hold_new_size got %0d want 5", filt_size);
    end
    feed(5, 16'h0505, 1'b0);
    wait_valid;
    tests++;
    if (wa.size() != 5) begin
      fails++;
      $display("FAIL hold_nwr got %0d want 5", wa.size());
    end
    for (int i = 0; i < wa.size() && i < 5; i++) begin
      tests++;
      if (wa[i] != i || wd[i] !== word(16'h0505, i)) begin
        fails++;
        $display("FAIL hold_wr%0d got %0d/%h want %0d/%h",
                 i, wa[i], wd[i], i, word(16'h0505, i));
      end
    end
    release_filt;
  endtask

  task automatic test_max;
    wa.delete(); wd.delete();
    start = 1'b1; filt_len = 4'd12;
    tick;
    start = 1'b0;
    feed(12, 16'h0101, 1'b1);
    wait_valid;
    tests++;
    if (wa.size() != 12 || filt_size !== 4'd12) begin
      fails++;
      $display("FAIL max_nwr got %0d/size %0d want 12/12",
               wa.size(), filt_size);
    end
    for (int i = 0; i < wa.size() && i < 12; i++) begin
      tests++;
      if (wa[i] != i || wd[i] !== word(16'h0101, i)) begin
        fails++;
        $display("FAIL max_wr%0d got %0d/%h want %0d/%h",
                 i, wa[i], wd[i], i, word(16'h0101, i));
      end
    end
    in_valid = 1'b1; in_data = 16'hDEAD;
    for (int i = 0; i < 4; i++) begin
      tick;
      tests++;
      if ({in_ready, spad_wen} !== 2'b00) begin
        fails++;
        $display("FAIL max_hold%0d ready/wen got %b%b want 00",
                 i, in_ready, spad_wen);
      end
    end
    in_valid = 1'b0;
    tests++;
    if (wa.size() != 12) begin
      fails++;
      $display("FAIL max_extra got %0d writes want 12", wa.size());
    end
    release_filt;
  endtask

  task automatic test_len_err;
    logic [3:0] bad [2];
    bad[0] = 4'd0; bad[1] = 4'd13;
    wa.delete(); wd.delete();
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; filt_len = bad[k];
      tick;
      start = 1'b0;
      tests++;
      if ({len_err, busy, in_ready} !== 3'b100) begin
        fails++;
        $display("FAIL len_err%0d err/busy/ready got %b%b%b want 100",
                 bad[k], len_err, busy, in_ready);
      end
      tick;
      tests++;
      if ({len_err, busy} !== 2'b00) begin
        fails++;
        $display("FAIL len_pulse%0d err/busy got %b%b want 00",
                 bad[k], len_err, busy);
      end
    end
    tests++;
    if (wa.size() != 0) begin
      fails++;
      $display("FAIL len_nwr got %0d want 0", wa.size());
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1; filt_len = 4'd4;
    tick;
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'hAAAA;
    tick;
    in_data = 16'hBBBB;
    tick;
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({in_ready, spad_wen, spad_waddr, spad_din, filt_valid,
         filt_size, busy, len_err} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs got %b wants all zero",
               {in_ready, spad_wen, spad_waddr, spad_din,
                filt_valid, filt_size, busy, len_err});
    end
    repeat (2) tick;
    rst = 1'b1;
    tick;
    wa.delete(); wd.delete();
    start = 1'b1; filt_len = 4'd4;
    tick;
    start = 1'b0;
    feed(4, 16'h0404, 1'b0);
    wait_valid;
    tests++;
    if (wa.size() != 4 || filt_size !== 4'd4) begin
      fails++;
      $display("FAIL midrst_nwr got %0d/size %0d want 4/4",
               wa.size(), filt_size);
    end
    for (int i = 0; i < wa.size() && i < 4; i++) begin
      tests++;
      if (wa[i] != i || wd[i] !== word(16'h0404, i)) begin
        fails++;
        $display("FAIL midrst_wr%0d got %0d/%h want %0d/%h",
                 i, wa[i], wd[i], i, word(16'h0404, i));
      end
    end
    release_filt;
  endtask

  task automatic test_ignored;
    wa.delete(); wd.delete();
    start = 1'b1; filt_len = 4'd3;
    tick;
    start = 1'b0;
    filt_release = 1'b1;
    in_valid = 1'b1; in_data = word(16'h0707, 0);
    tick;
    filt_release = 1'b0;
    tests++;
    if ({busy, in_ready, filt_valid} !== 3'b110) begin
      fails++;
      $display("FAIL ign_rel busy/ready/valid got %b%b%b want 110",
               busy, in_ready, filt_valid);
    end
    in_data = word(16'h0707, 1);
    tick;
    in_data = word(16'h0707, 2);
    tick;
    in_valid = 1'b0;
    start = 1'b1; filt_len = 4'd7;
    tick;
    start = 1'b0;
    tests++;
    if ({len_err, filt_valid} !== 2'b00) begin
      fails++;
      $display("FAIL ign_start err/valid got %b%b want 00",
               len_err, filt_valid);
    end
    tick;
    tests++;
    if ({filt_valid, filt_size} !== {1'b1, 4'd3}) begin
      fails++;
      $display("FAIL ign_done valid/size got %b/%0d want 1/3",
               filt_valid, filt_size);
    end
    tests++;
    if (wa.size() != 3) begin
      fails++;
      $display("FAIL ign_nwr got %0d want 3", wa.size());
    end
    for (int i = 0; i < wa.size() && i < 3; i++) begin
      tests++;
      if (wa[i] != i || wd[i] !== word(16'h0707, i)) begin
        fails++;
        $display("FAIL ign_wr%0d got %0d/%h want %0d/%h",
                 i, wa[i], wd[i], i, word(16'h0707, i));
      end
    end
    release_filt;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_hold_start;
    test_max;
    test_len_err;
    test_reset_mid;
    test_ignored;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
